// File: rtl/regbank_pkg.sv
// ============================================================================
// Module   : regbank_pkg
// Purpose  : Shared sizing constants and types for the regbank_v1 register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regbank_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage : regbank_pkg

`default_nettype wire

// File: rtl/regbank_rd_port.sv
// ============================================================================
// Module   : regbank_rd_port
// Purpose  : Combinational read mux; address ZERO_REG always returns zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbank_rd_port
  import regbank_pkg::*;
(
  input  reg_data_t i_regs [NUM_REGS],
  input  reg_addr_t i_addr,
  output reg_data_t o_data
);

  reg_data_t w_data;

  // Register 0 is forced here so its storage never needs to be trusted.
  always_comb begin
    w_data = '0;
    if (i_addr != ZERO_REG) begin
      w_data = i_regs[i_addr];
    end
  end

  assign o_data = w_data;

endmodule : regbank_rd_port

`default_nettype wire

// File: rtl/regbank_v1.sv
// ============================================================================
// Module   : regbank_v1
// Purpose  : 32 x 32 register file, two combinational reads, one write per clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbank_v1
  import regbank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] dr,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2
);

  reg_data_t r_regs [NUM_REGS];

  // No write enable: every edge out of reset writes, and dr == 0 is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (dr != ZERO_REG) begin
      r_regs[dr] <= wrData;
    end
  end

  regbank_rd_port u_rd_port1 (
    .i_regs (r_regs),
    .i_addr (sr1),
    .o_data (rdData1)
  );

  regbank_rd_port u_rd_port2 (
    .i_regs (r_regs),
    .i_addr (sr2),
    .o_data (rdData2)
  );

endmodule : regbank_v1

`default_nettype wire

// File: tb/tb_regbank_v1.sv
// ============================================================================
// Module   : tb_regbank_v1
// Purpose  : Self-checking bench for regbank_v1 against a simple array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/10ps

module tb_regbank_v1;
  import regbank_pkg::*;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] dr;
  logic [ADDR_W-1:0] sr1;
  logic [ADDR_W-1:0] sr2;
  logic [DATA_W-1:0] rdData1;
  logic [DATA_W-1:0] rdData2;

  int checks;
  int failures;
  logic [DATA_W-1:0] exp_regs [NUM_REGS];

  regbank_v1 dut (
    .clk     (clk),
    .rst     (rst),
    .wrData  (wrData),
    .dr      (dr),
    .sr1     (sr1),
    .sr2     (sr2),
    .rdData1 (rdData1),
    .rdData2 (rdData2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
  endtask

  // Reset held 0..11; edge at 5 must not write despite a live dr/wrData.
  task automatic test_reset();
    rst = 1'b0;
    dr = 5'd3;
    wrData = 32'h1234_5678;
    sr1 = '0;
    sr2 = '0;
    #6;
    for (int i = 0; i < NUM_REGS / 2; i++) begin
      sr1 = 5'(2 * i);
      sr2 = 5'(2 * i + 1);
      #0.2;
      checks++;
      if (rdData1 !== '0) begin
        failures++;
        $display("FAIL reset_rd1 r%0d: got %h expected %h", sr1, rdData1, 32'h0);
      end
      checks++;
      if (rdData2 !== '0) begin
        failures++;
        $display("FAIL reset_rd2 r%0d: got %h expected %h", sr2, rdData2, 32'h0);
      end
    end
    #1.8;
    rst = 1'b1;
  endtask

  task automatic test_basic_write();
    dr = 5'd9;
    wrData = 32'd10;
    sr1 = 5'd9;
    sr2 = 5'd0;
    #1;
    checks++;
    if (rdData1 !== 32'd0) begin
      failures++;
      $display("FAIL basic_before_edge: got %h expected %h", rdData1, 32'd0);
    end
    @(posedge clk); #1;
    exp_regs[9] = 32'd10;
    checks++;
    if (rdData1 !== 32'd10) begin
      failures++;
      $display("FAIL basic_after_edge: got %h expected %h", rdData1, 32'd10);
    end
  endtask

  task automatic test_second_write_zero();
    dr = 5'd8;
    wrData = 32'd19;
    sr1 = 5'd0;
    sr2 = 5'd8;
    #1;
    checks++;
    if (rdData1 !== 32'd0 || rdData2 !== 32'd0) begin
      failures++;
      $display("FAIL second_before_edge: got %h/%h expected %h/%h", rdData1, rdData2, 32'd0, 32'd0);
    end
    @(posedge clk); #1;
    exp_regs[8] = 32'd19;
    checks++;
    if (rdData1 !== 32'd0 || rdData2 !== 32'd19) begin
      failures++;
      $display("FAIL second_after_edge: got %h/%h expected %h/%h", rdData1, rdData2, 32'd0, 32'd19);
    end
    sr1 = 5'd9;
    #1;
    checks++;
    if (rdData1 !== exp_regs[9]) begin
      failures++;
      $display("FAIL r9_retained: got %h expected %h", rdData1, exp_regs[9]);
    end
  endtask

  task automatic test_last_value_wins();
    dr = 5'd6;
    wrData = 32'd11;
    #1;
    wrData = 32'd20;
    sr1 = 5'd8;
    sr2 = 5'd6;
    #1;
    checks++;
    if (rdData1 !== 32'd19 || rdData2 !== 32'd0) begin
      failures++;
      $display("FAIL lastval_before_edge: got %h/%h expected %h/%h", rdData1, rdData2, 32'd19, 32'd0);
    end
    @(posedge clk); #1;
    exp_regs[6] = 32'd20;
    checks++;
    if (rdData1 !== 32'd19 || rdData2 !== 32'd20) begin
      failures++;
      $display("FAIL lastval_after_edge: got %h/%h expected %h/%h", rdData1, rdData2, 32'd19, 32'd20);
    end
  endtask

  task automatic test_zero_protect();
    dr = 5'd0;
    wrData = 32'hDEAD_BEEF;
    sr1 = 5'd0;
    sr2 = 5'd9;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rdData1 !== 32'd0 || rdData2 !== exp_regs[9]) begin
        failures++;
        $display("FAIL zero_protect edge%0d: got %h/%h expected %h/%h", k, rdData1, rdData2, 32'd0, exp_regs[9]);
      end
    end
  endtask

  // Entered at posedge+1; reset asserts and releases between edges.
  task automatic test_async_reset();
    dr = 5'd0;
    sr1 = 5'd6;
    sr2 = 5'd8;
    #1;
    checks++;
    if (rdData1 !== exp_regs[6] || rdData2 !== exp_regs[8]) begin
      failures++;
      $display("FAIL areset_pre: got %h/%h expected %h/%h", rdData1, rdData2, exp_regs[6], exp_regs[8]);
    end
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rdData1 !== 32'd0 || rdData2 !== 32'd0) begin
      failures++;
      $display("FAIL areset_no_edge: got %h/%h expected %h/%h", rdData1, rdData2, 32'd0, 32'd0);
    end
    dr = 5'd5;
    wrData = $urandom;
    sr1 = 5'd5;
    @(posedge clk); #1;
    checks++;
    if (rdData1 !== 32'd0) begin
      failures++;
      $display("FAIL areset_write_blocked: got %h expected %h", rdData1, 32'd0);
    end
    dr = 5'd0;
    #1;
    rst = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      sr1 = 5'(i);
      sr2 = 5'(NUM_REGS - 1 - i);
      #0.1;
      checks++;
      if (rdData1 !== 32'd0 || rdData2 !== 32'd0) begin
        failures++;
        $display("FAIL areset_cleared r%0d/r%0d: got %h/%h expected 0/0", sr1, sr2, rdData1, rdData2);
      end
    end
    @(posedge clk); #1;
  endtask

  // Decoy dr/wrData just after each edge show that only edge values matter.
  task automatic test_random(input int n_cycles);
    for (int n = 0; n < n_cycles; n++) begin
      dr = 5'($urandom);
      wrData = $urandom;
      #2;
      dr = 5'($urandom_range(0, NUM_REGS - 1));
      wrData = $urandom;
      sr1 = 5'($urandom);
      sr2 = (n % 5 == 0) ? sr1 : 5'($urandom);
      #1;
      checks++;
      if (rdData1 !== exp_regs[sr1] || rdData2 !== exp_regs[sr2]) begin
        failures++;
        $display("FAIL random_pre n%0d r%0d/r%0d: got %h/%h expected %h/%h",
                 n, sr1, sr2, rdData1, rdData2, exp_regs[sr1], exp_regs[sr2]);
      end
      if (dr != 0) exp_regs[dr] = wrData;
      @(posedge clk); #1;
      checks++;
      if (rdData1 !== exp_regs[sr1] || rdData2 !== exp_regs[sr2]) begin
        failures++;
        $display("FAIL random_post n%0d r%0d/r%0d: got %h/%h expected %h/%h",
                 n, sr1, sr2, rdData1, rdData2, exp_regs[sr1], exp_regs[sr2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < NUM_REGS; i++) begin
      dr = 5'(i);
      wrData = $urandom;
      sr1 = 5'(i - 1);
      sr2 = 5'(i);
      #1;
      checks++;
      if (rdData1 !== exp_regs[i - 1] || rdData2 !== exp_regs[i]) begin
        failures++;
        $display("FAIL b2b_pre r%0d: got %h/%h expected %h/%h",
                 i, rdData1, rdData2, exp_regs[i - 1], exp_regs[i]);
      end
      exp_regs[i] = wrData;
      @(posedge clk); #1;
      checks++;
      if (rdData2 !== exp_regs[i]) begin
        failures++;
        $display("FAIL b2b_post r%0d: got %h expected %h", i, rdData2, exp_regs[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_clear();
    test_reset();
    test_basic_write();
    test_second_write_zero();
    test_last_value_wins();
    test_zero_protect();
    test_async_reset();
    test_random(200);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regbank_v1

`default_nettype wire
